serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range 1..64.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit, meaning operands are offered.
REQ-005 The block SHALL have port in_ready, output, 1 bit, meaning the block can accept operands.
REQ-006 The block SHALL have port a, input, WIDTH bits, operand A, unsigned or two's complement.
REQ-007 The block SHALL have port b, input, WIDTH bits, operand B.
REQ-008 The block SHALL have port cin, input, 1 bit, the carry-in, used only when sub=0.
REQ-009 The block SHALL have port sub, input, 1 bit, selecting the mode: 0 = add, 1 = subtract.
REQ-010 The block SHALL have port out_valid, output, 1 bit, meaning the result is available.
REQ-011 The block SHALL have port out_ready, input, 1 bit, meaning the consumer accepts the result.
REQ-012 The block SHALL have port sum, output, WIDTH bits, the result.
REQ-013 The block SHALL have port cout, output, 1 bit, the carry out of the MSB (for subtract: 1 = no borrow).
REQ-014 The block SHALL have port ovf, output, 1 bit, the signed overflow flag.
REQ-015 The block SHALL have port busy, output, 1 bit, high while in state RUN.

Function
REQ-016 The block SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-017 In IDLE, in_ready SHALL be 1; in RUN and DONE it SHALL be 0.
REQ-018 An input handshake occurs on an edge where in_valid=1 and in_ready=1; on it the block SHALL capture A=a, B=(sub ? ~b : b) and carry=(sub ? 1 : cin), clear the bit counter and enter RUN.
REQ-019 Inputs SHALL be ignored on every edge without a handshake.
REQ-020 In RUN, on each edge the block SHALL process bit i (LSB first, i = counter value) with one 1-bit full adder: sum[i] = A[i]^B[i]^carry; carry <= majority(A[i], B[i], carry).
REQ-021 The full adder SHALL be the only arithmetic resource; no WIDTH-bit adder is permitted.
REQ-022 After bit WIDTH-1 is processed, the block SHALL set cout = final carry and ovf = (carry into MSB) XOR (carry out of MSB), then enter DONE.
REQ-023 Latency SHALL be exactly WIDTH edges from the input handshake edge to the first cycle with out_valid=1.
REQ-024 out_valid SHALL be 1 only in DONE.
REQ-025 sum, cout and ovf SHALL hold stable in DONE until the edge where out_valid=1 and out_ready=1, on which the block SHALL return to IDLE.
REQ-026 If out_ready is already 1 on DONE entry, the result SHALL be accepted on the first DONE edge; a new input handshake is possible at the earliest one cycle later.
REQ-027 The bit counter SHALL be $clog2(WIDTH) bits wide, minimum 1 bit, and SHALL never wrap within an operation.
REQ-028 For WIDTH=1, the block SHALL spend one cycle in RUN and ovf SHALL equal cin_to_msb XOR cout.
REQ-029 Between operations, sum, cout and ovf SHALL retain the last result; partial sum bits MAY be visible while busy=1.

Reset
REQ-030 While rst_n=0, the block SHALL immediately force state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, ovf=0 and counter=0, regardless of clk.
REQ-031 Reset asserted mid-RUN or in DONE SHALL abort the operation with no result delivered.
REQ-032 After rst_n deasserts, the first handshake SHALL be possible on the first rising clk edge.

Verification (WIDTH=8 unless stated)
REQ-033 add a=0xFF, b=0x01, cin=0 -> after 8 edges: sum=0x00, cout=1, ovf=0.
REQ-034 add a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1; add a=0x10, b=0x20, cin=1 -> sum=0x31, cout=0, ovf=0.
REQ-035 sub a=0x05, b=0x07 -> sum=0xFE, cout=0, ovf=0; sub a=0x80, b=0x01 -> sum=0x7F, cout=1, ovf=1.
REQ-036 Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, sum, cout and ovf stable, in_ready=0, in_valid pulses ignored; then out_ready=1 -> IDLE next edge.
REQ-037 Reset mid-RUN: assert rst_n=0 at bit 3 -> outputs reach reset values asynchronously; the next operation 0x01+0x01 gives sum=0x02.
REQ-038 WIDTH=1: all 8 combinations of {a, b, cin} with sub=0 -> {sum, cout} matches the 1-bit full-adder truth table, checked against a file-driven golden output.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full adder walks the operands LSB first,
// producing a WIDTH-bit result with carry-out and signed overflow.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             cout_reg;
    logic             ovf_reg;
    logic             fa_s;
    logic             fa_c;

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid may not depend on ready, and data is only sampled then.

    // The operand registers shift right each RUN cycle, so bit 0 is always the
    // bit currently being added.
    assign fa_s = a_reg[0] ^ b_reg[0] ^ carry;
    assign fa_c = (a_reg[0] & b_reg[0]) | (a_reg[0] & carry) | (b_reg[0] & carry);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            sum_reg  <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            cout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            a_reg <= a;
            b_reg <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_reg <= a_reg >> 1;
            b_reg <= b_reg >> 1;
            carry <= fa_c;
            for (int i = 0; i < WIDTH; i++) begin
                if (cnt == CW'(i)) sum_reg[i] <= fa_s;
            end
            // The counter parks on the last bit instead of wrapping.
            if (cnt == LAST) begin
                cout_reg <= fa_c;
                ovf_reg  <= carry ^ fa_c;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign sum  = sum_reg;
    assign cout = cout_reg;
    assign ovf  = ovf_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: randomized operations checked every cycle against an
// arithmetic model, plus directed cases, backpressure, mid-run reset, WIDTH=1.
module tb_serial_adder;

    localparam int W = 8;

    // clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    logic w1_in_valid = 1'b0;
    logic w1_in_ready;
    logic w1_a = 1'b0;
    logic w1_b = 1'b0;
    logic w1_cin = 1'b0;
    logic w1_out_valid;
    logic w1_sum;
    logic w1_cout;
    logic w1_ovf;
    logic w1_busy;

    serial_adder #(.WIDTH(W)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(w1_in_valid), .in_ready(w1_in_ready),
        .a(w1_a), .b(w1_b), .cin(w1_cin), .sub(1'b0), .out_valid(w1_out_valid),
        .out_ready(1'b1), .sum(w1_sum), .cout(w1_cout), .ovf(w1_ovf), .busy(w1_busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain (W+1)-bit arithmetic; overflow from operand/result signs.
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mc, input logic ms);
        logic [W-1:0] bb;
        logic         c0;
        logic [W:0]   t;
        logic         v;
        bb = ms ? ~mb : mb;
        c0 = ms ? 1'b1 : mc;
        t  = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, c0};
        v  = (ma[W-1] == bb[W-1]) && (t[W-1] != ma[W-1]);
        return {v, t[W], t[W-1:0]};
    endfunction

    // scoreboard: {ovf, cout, sum}
    logic [W+1:0] exp_q[$];
    logic [W+1:0] last_res = '0;
    logic         pending  = 1'b0;
    int           rdy_cyc  = 0;
    int           cyc      = 0;
    logic         exp_ov;

    always @(posedge clk) cyc++;

    always @(negedge rst_n) begin
        pending  = 1'b0;
        exp_q.delete();
        last_res = '0;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            exp_ov = pending && (cyc >= rdy_cyc);
            check("out_valid", out_valid, exp_ov);
            check("in_ready", in_ready, !pending);
            check("busy", busy, pending && (cyc < rdy_cyc));
            if (exp_ov)
                check("result", {ovf, cout, sum}, exp_q[0]);
            else if (!pending)
                check("retained", {ovf, cout, sum}, last_res);
            if (exp_ov && out_ready) begin
                last_res = exp_q.pop_front();
                pending  = 1'b0;
            end else if (!pending && in_valid) begin
                exp_q.push_back(model(a, b, cin, sub));
                pending = 1'b1;
                rdy_cyc = cyc + 1 + W;
            end
        end
    end

    // out_ready driver: random or forced
    logic rand_ready  = 1'b0;
    logic force_ready = 1'b1;
    initial forever begin
        @(posedge clk);
        #1;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : force_ready;
    end

    // driver tasks
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tc, input logic ts);
        int n;
        n = 0;
        a = ta; b = tb; cin = tc; sub = ts;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        check("handshake_timeout", n < 200, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    endtask

    task automatic wait_result();
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("result_timeout", n < 100, 1);
    endtask

    task automatic run_check(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                             input logic ts, input logic [W-1:0] es, input logic ec,
                             input logic ev);
        check("model_pin", model(ta, tb, tc, ts), {ev, ec, es});
        do_op(ta, tb, tc, ts);
        wait_result();
        check("lit_sum", sum, es);
        check("lit_cout", cout, ec);
        check("lit_ovf", ovf, ev);
        @(posedge clk);
        #1;
    endtask

    logic [1:0] golden [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_result", {ovf, cout, sum}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // WIDTH=1 full-adder truth table
        for (int i = 0; i < 8; i++) begin
            w1_a = i[2]; w1_b = i[1]; w1_cin = i[0];
            w1_in_valid = 1'b1;
            @(posedge clk);
            #1;
            w1_in_valid = 1'b0;
            check("w1_busy", w1_busy, 1);
            @(posedge clk);
            #1;
            check("w1_out_valid", w1_out_valid, 1);
            check("w1_sum_cout", {w1_cout, w1_sum}, golden[i]);
            check("w1_ovf", w1_ovf, w1_cin ^ golden[i][1]);
            @(posedge clk);
            #1;
        end

        // directed arithmetic
        run_check(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        run_check(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        run_check(8'h10, 8'h20, 1'b1, 1'b0, 8'h31, 1'b0, 1'b0);
        run_check(8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
        run_check(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

        // backpressure with ignored input pulses
        force_ready = 1'b0;
        @(posedge clk);
        #2;
        do_op(8'h3C, 8'h5A, 1'b1, 1'b0);
        wait_result();
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            a = W'($urandom); b = W'($urandom);
            check("bp_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        force_ready = 1'b1;
        @(posedge clk);
        #2;
        @(posedge clk);
        #1;
        check("bp_released_valid", out_valid, 0);
        check("bp_released_ready", in_ready, 1);

        // reset while bit 3 is in flight
        do_op(8'h55, 8'h33, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_in_ready", in_ready, 1);
        check("arst_out_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_result", {ovf, cout, sum}, 0);
        @(posedge clk);
        #1;
        check("arst_held", {in_ready, out_valid, busy}, 3'b100);
        rst_n = 1'b1;
        run_check(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0);

        // randomized operations with random consumer stalls
        rand_ready = 1'b1;
        for (int n = 0; n < 150; n++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        rand_ready  = 1'b0;
        force_ready = 1'b1;
        repeat (W + 6) @(posedge clk);
        #1;
        check("drained", pending, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
